// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_BE_W   = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a load/store requester and the responder.
import dmem_pkg::*;

interface data_mem_responder_if;

    logic                   req_valid;
    logic                   req_ready;
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            addr;
    logic [DMEM_WORD_W-1:0] wdata;
    logic [DMEM_BE_W-1:0]   byte_en;
    logic                   resp_valid;
    logic [DMEM_WORD_W-1:0] rdata;
    logic                   resp_err;

    modport master (
        output req_valid, mem_read, mem_write, addr, wdata, byte_en,
        input  req_ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  req_valid, mem_read, mem_write, addr, wdata, byte_en,
        output req_ready, resp_valid, rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Registered read data appears the cycle after a read-enabled edge; no reset on contents.
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_en,
    input  logic [DMEM_BE_W-1:0]   i_we,
    input  logic [AW-1:0]          i_addr,
    input  logic [DMEM_WORD_W-1:0] i_wdata,
    output logic [DMEM_WORD_W-1:0] o_rdata
);

    logic [DMEM_WORD_W-1:0] r_mem [DEPTH];
    logic [DMEM_WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < DMEM_BE_W; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            if (i_we == '0) begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one transaction at a time, response WAIT_CYCLES+1 cycles after accept.
// req_ready is high only while idle and out of reset; requesters simply hold req_valid.
import dmem_pkg::*;

module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    data_mem_responder_if.slave  bus
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt, w_cnt_next;
    logic [31:0]            r_addr;
    logic [DMEM_WORD_W-1:0] r_wdata;
    logic [DMEM_BE_W-1:0]   r_be;
    logic                   r_rd, r_wr, r_err, r_load;

    logic                   w_accept, w_resp_entry, w_err;
    logic [31:0]            w_cur_addr;
    logic [DMEM_WORD_W-1:0] w_cur_wdata;
    logic [DMEM_BE_W-1:0]   w_cur_be;
    logic                   w_cur_rd, w_cur_wr;
    logic [DMEM_WORD_W-1:0] w_ram_rdata;

    assign w_accept = bus.req_valid && (r_state == IDLE) && !i_reset;

    // With zero wait states RESP is entered on the accept edge itself, before the
    // request registers are loaded, so the live inputs feed the array in IDLE.
    assign w_cur_addr  = (r_state == IDLE) ? bus.addr      : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? bus.wdata     : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? bus.byte_en   : r_be;
    assign w_cur_rd    = (r_state == IDLE) ? bus.mem_read  : r_rd;
    assign w_cur_wr    = (r_state == IDLE) ? bus.mem_write : r_wr;

    assign w_err = (w_cur_addr[1:0] != 2'b00)
                || (w_cur_addr >= 32'(4 * DEPTH))
                || (w_cur_rd == w_cur_wr);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = WAIT_LD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_resp_entry = (w_next == RESP) && !i_reset;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_resp_entry) begin
                r_err  <= w_err;
                r_load <= w_cur_rd && !w_err;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_be    <= bus.byte_en;
            r_rd    <= bus.mem_read;
            r_wr    <= bus.mem_write;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clock),
        .i_en    (w_resp_entry && !w_err),
        .i_we    (w_cur_be & {DMEM_BE_W{w_cur_wr}}),
        .i_addr  (w_cur_addr[AW+1:2]),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign bus.req_ready  = (r_state == IDLE) && !i_reset;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) && r_err;
    assign bus.rdata      = ((r_state == RESP) && r_load) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a two-wait-state responder and a zero-wait-state responder on one clock.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v2 = 1'b0, v0 = 1'b0;
    logic        t_rd = 1'b0, t_wr = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic [3:0]  t_be = '0;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    assign bus2.req_valid = v2;
    assign bus2.mem_read  = t_rd;
    assign bus2.mem_write = t_wr;
    assign bus2.addr      = t_addr;
    assign bus2.wdata     = t_wdata;
    assign bus2.byte_en   = t_be;
    assign bus0.req_valid = v0;
    assign bus0.mem_read  = t_rd;
    assign bus0.mem_write = t_wr;
    assign bus0.addr      = t_addr;
    assign bus0.wdata     = t_wdata;
    assign bus0.byte_en   = t_be;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus2)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    // One transaction; inputs are scrambled right after the accept edge.
    task automatic do_req(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int lat, output logic err, output logic [31:0] rdat);
        @(negedge clk);
        t_rd = rd; t_wr = wr; t_addr = a; t_wdata = d; t_be = be;
        if (sel == 0) v0 = 1'b1; else v2 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v2 = 1'b0;
        t_addr = $urandom; t_wdata = $urandom; t_be = 4'($urandom);
        t_rd = 1'($urandom); t_wr = 1'($urandom);
        lat = -1; err = 1'b0; rdat = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((sel == 0) ? bus0.resp_valid : bus2.resp_valid) begin
                lat  = k;
                err  = (sel == 0) ? bus0.resp_err : bus2.resp_err;
                rdat = (sel == 0) ? bus0.rdata : bus2.rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus2.req_ready !== 1'b1) $display("FAIL reset_ready2: got %b want 1", bus2.req_ready); else n_pass++;
        n_total++; if (bus0.req_ready !== 1'b1) $display("FAIL reset_ready0: got %b want 1", bus0.req_ready); else n_pass++;
        n_total++; if (bus2.resp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus2.resp_valid); else n_pass++;
        n_total++; if (bus2.resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus2.resp_err); else n_pass++;
        n_total++; if (bus2.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus2.rdata); else n_pass++;
    endtask

    task automatic test_store_load();
        int lat; logic err; logic [31:0] rd;
        do_req(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, rd);
        n_total++; if (lat !== 3) $display("FAIL store_latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL store_err: got %b want 0", err); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL store_rdata: got %h want 0", rd); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (lat !== 3) $display("FAIL load_latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL load_err: got %b want 0", err); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", rd); else n_pass++;
    endtask

    task automatic test_byte_en();
        int lat; logic err; logic [31:0] rd;
        do_req(2, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, err, rd);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'hDEADBEAA) $display("FAIL be_0001: got %h want deadbeaa", rd); else n_pass++;
        do_req(2, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b1010, lat, err, rd);
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'h11AD33AA) $display("FAIL be_1010: got %h want 11ad33aa", rd); else n_pass++;
    endtask

    task automatic test_errors();
        int lat; logic err; logic [31:0] rd;
        do_req(2, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL misalign_load: lat %0d err %b want 3 1", lat, err); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL misalign_rdata: got %h want 0", rd); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL range_load: lat %0d err %b want 3 1", lat, err); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL range_rdata: got %h want 0", rd); else n_pass++;
        do_req(2, 1'b0, 1'b1, 32'h12, 32'h55555555, 4'hF, lat, err, rd);
        n_total++; if (err !== 1'b1) $display("FAIL misalign_store_err: got %b want 1", err); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'h11AD33AA) $display("FAIL misalign_unchanged: got %h want 11ad33aa", rd); else n_pass++;
        do_req(2, 1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, lat, err, rd);
        do_req(2, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, err, rd);
        n_total++; if (err !== 1'b1) $display("FAIL range_store_err: got %b want 1", err); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'h0BADC0DE) $display("FAIL range_unchanged: got %h want 0badc0de", rd); else n_pass++;
    endtask

    task automatic test_rw_both();
        int lat; logic err; logic [31:0] rd;
        do_req(2, 1'b0, 1'b1, 32'h20, 32'h01020304, 4'hF, lat, err, rd);
        do_req(2, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat, err, rd);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL rw_both: lat %0d err %b want 3 1", lat, err); else n_pass++;
        do_req(2, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL rw_none: lat %0d err %b want 3 1", lat, err); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'h01020304) $display("FAIL rw_both_unchanged: got %h want 01020304", rd); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        int lat; logic err; logic [31:0] rd; logic seen;
        do_req(2, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, err, rd);
        @(negedge clk);
        t_rd = 1'b0; t_wr = 1'b1; t_addr = 32'h30; t_wdata = 32'h12345678; t_be = 4'hF; v2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
        @(negedge clk);
        seen = bus2.resp_valid;
        rst = 1'b1;
        @(negedge clk);
        seen = seen | bus2.resp_valid;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus2.req_ready !== 1'b1) $display("FAIL rst_wait_ready: got %b want 1", bus2.req_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            seen = seen | bus2.resp_valid;
            @(negedge clk);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rst_wait_noresp: got %b want 0", seen); else n_pass++;
        do_req(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, err, rd);
        n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL rst_wait_data: got %h want cafef00d", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; logic err; logic [31:0] rd; int nresp;
        nresp = 0;
        @(negedge clk);
        t_rd = 1'b0; t_wr = 1'b1; t_be = 4'hF; t_addr = 32'h40; t_wdata = 32'hA0000000;
        v0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if ({bus0.req_ready, bus0.resp_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL b2b_cycle%0d: ready/valid %b%b want %s", i, bus0.req_ready, bus0.resp_valid, (i % 2 == 0) ? "10" : "01");
            else n_pass++;
            if (bus0.resp_valid === 1'b1) nresp++;
            if (i % 2 == 1) begin
                t_addr  = 32'h40 + 32'(4 * ((i + 1) / 2));
                t_wdata = 32'hA0000000 + 32'((i + 1) / 2);
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus0.resp_valid === 1'b1) nresp++;
            @(negedge clk);
        end
        n_total++; if (nresp !== 4) $display("FAIL b2b_count: got %0d want 4", nresp); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, lat, err, rd);
            n_total++;
            if (lat !== 1 || rd !== 32'hA0000000 + 32'(i))
                $display("FAIL b2b_word%0d: lat %0d data %h want 1 %h", i, lat, rd, 32'hA0000000 + 32'(i));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_en();
        test_errors();
        test_rw_both();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters: DEPTH, default 256, number of 32-bit words stored.
REQ-002 Parameters: WAIT_CYCLES, default 2, extra wait states between request accept and response (0..15).
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  requester presents a transaction.
REQ-006 req_ready  out  1  responder accepts a transaction this cycle.
REQ-007 mem_read  in  1  transaction is a load.
REQ-008 mem_write  in  1  transaction is a store.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  store data.
REQ-011 byte_en  in  4  store byte enables; bit i writes wdata[8i+7:8i].
REQ-012 resp_valid  out  1  one-cycle response strobe.
REQ-013 rdata  out  32  load data; valid only with resp_valid on a load.
REQ-014 resp_err  out  1  transaction rejected; valid only with resp_valid.

Function
REQ-015 States: IDLE, WAIT, RESP. req_ready = 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready. At accept, register addr, wdata, byte_en, mem_read and mem_write.
REQ-017 Transitions:
- IDLE -> WAIT on accept when WAIT_CYCLES > 0.
- IDLE -> RESP on accept when WAIT_CYCLES = 0.
- WAIT -> RESP after WAIT_CYCLES cycles in WAIT, counted by a 4-bit down-counter.
- RESP -> IDLE unconditionally.
REQ-018 Latency: accept at edge N gives resp_valid high for exactly the cycle after edge N+1+WAIT_CYCLES.
REQ-019 Word index = addr[log2(DEPTH)+1:2].
REQ-020 Error condition is any of:
- addr[1:0] != 0;
- addr >= 4*DEPTH;
- mem_read = mem_write, both 0 or both 1.
On error: resp_err = 1, rdata = 0, and the array is not modified.
REQ-021 Store without error: enabled bytes are written at the RESP-entry edge; disabled bytes are unchanged. resp_err = 0 and rdata = 0.
REQ-022 Load without error: rdata = word at the index, sampled so that it reflects every store completed before this accept.
REQ-023 Back-to-back: the earliest next accept is the cycle after RESP. A store followed by a load to the same word returns the new data.
REQ-024 Request inputs are ignored outside an accept cycle. Changing them during WAIT/RESP has no effect.
REQ-025 req_valid is high-when-not-ready tolerant: the requester holds it, and no transaction is lost or duplicated.

Reset
REQ-026 While reset = 1 at an edge: state becomes IDLE, the counter is cleared, resp_valid = 0, resp_err = 0 and rdata = 0. req_ready = 1 from the cycle after reset is deasserted.
REQ-027 Reset during WAIT or RESP abandons the transaction: no array write and no response.
REQ-028 Array contents are not cleared by reset.

Structure
REQ-029 Shared package dmem_pkg holds:
- state enum {IDLE, WAIT, RESP};
- DMEM_WORD_W = 32;
- DMEM_BE_W = 4.
REQ-030 Storage lives in one sub-module, dmem_array: a single-port synchronous RAM with per-byte write enable. All control stays in data_mem_responder.

Verification
REQ-031 WAIT_CYCLES = 2. Store 0xDEADBEEF to 0x10 with byte_en = 4'hF, then load 0x10. Required:
- the store response arrives 3 cycles after accept with resp_err = 0;
- the load returns rdata = 0xDEADBEEF.
REQ-032 Store 0x000000AA to 0x10 with byte_en = 4'b0001 over 0xDEADBEEF, then load 0x10. Required: rdata = 0xDEADBEAA.
REQ-033 Load addr 0x13 and load addr 0x400 (DEPTH = 256). Required: each gives resp_valid with resp_err = 1 and rdata = 0, and the array is unchanged.
REQ-034 Request with mem_read = mem_write = 1 at 0x20. Required: resp_err = 1 and word 0x20 is unchanged.
REQ-035 Reset asserted during WAIT of a store 0x12345678 to 0x30. Required:
- no resp_valid;
- req_ready = 1 the cycle after reset deasserts;
- a later load of 0x30 returns the prior contents.
REQ-036 WAIT_CYCLES = 0, req_valid held high for four stores. Required:
- resp_valid every second cycle;
- req_ready toggles 1/0;
- exactly four responses.
